wb_regfile_scoreboard: RTL and testbench

//  Write-back end of the MEM/WB interface: 32x32 GPR file written from the WB stage,

---
 rtl/cpu_pkg.sv | 10 +
 rtl/reg_pending_ctr.sv | 36 +++
 rtl/wb_regfile_scoreboard.sv | 89 ++++++++
 tb/tb_wb_regfile_scoreboard.sv | 130 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and register address type.
package cpu_pkg;
    localparam int NREG   = 32;
    localparam int DW     = 32;
    localparam int PEND_W = 2;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_pending_ctr.sv
// One per-register pending-write counter: saturates at max on issue, floors at 0 on write-back.
module reg_pending_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_cnt,
    output logic              o_ovf
);
    localparam logic [PEND_W-1:0] CNT_MAX  = '1;
    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [PEND_W-1:0] r_cnt;
    logic              w_inc_only;
    logic              w_dec_only;

    assign w_inc_only = i_inc && !i_dec;
    assign w_dec_only = i_dec && !i_inc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= CNT_ZERO;
        end else if (w_inc_only && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else if (w_dec_only && r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_cnt = r_cnt;
    // Simultaneous issue and write-back leaves the count alone, so it cannot overflow.
    assign o_ovf = w_inc_only && (r_cnt == CNT_MAX);
endmodule

// File: rtl/wb_regfile_scoreboard.sv
// WB-stage GPR file with two bypassed ID read ports and a per-register pending-write scoreboard.
module wb_regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG   = cpu_pkg::NREG,
    parameter int DW     = cpu_pkg::DW,
    parameter int PEND_W = cpu_pkg::PEND_W
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      WB_RegWre,
    input  reg_addr_t WB_Reg_RD,
    input  logic [DW-1:0] WB_DataBus,
    input  reg_addr_t ID_Reg_RS,
    input  reg_addr_t ID_Reg_RT,
    output logic [DW-1:0] ID_RS_Data,
    output logic [DW-1:0] ID_RT_Data,
    input  logic      ID_Issue,
    input  reg_addr_t ID_Issue_RD,
    output logic      ID_RS_Busy,
    output logic      ID_RT_Busy,
    output logic      SB_Overflow
);
    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [NREG-1:0][DW-1:0]     r_gpr;
    logic [NREG-1:0][PEND_W-1:0] w_cnt;
    logic [NREG-1:0]             w_ovf_hit;
    logic                        r_ovf;
    logic                        w_wr_en;

    assign w_wr_en = WB_RegWre && (WB_Reg_RD != REG_ZERO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_gpr <= '0;
        end else if (w_wr_en) begin
            r_gpr[WB_Reg_RD] <= WB_DataBus;
        end
    end

    // r0 has no counter: it is never busy and issues to it are dropped.
    assign w_cnt[0]     = CNT_ZERO;
    assign w_ovf_hit[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_pend
        reg_pending_ctr #(.PEND_W(PEND_W)) u_ctr (
            .CLK   (CLK),
            .RST   (RST),
            .i_inc (ID_Issue && (ID_Issue_RD == reg_addr_t'(g))),
            .i_dec (WB_RegWre && (WB_Reg_RD == reg_addr_t'(g))),
            .o_cnt (w_cnt[g]),
            .o_ovf (w_ovf_hit[g])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (|w_ovf_hit) begin
            r_ovf <= 1'b1;
        end
    end

    assign SB_Overflow = r_ovf;

    function automatic logic [DW-1:0] rd_port(input reg_addr_t a,
                                              input logic [NREG-1:0][DW-1:0] gpr,
                                              input logic wr_en, input reg_addr_t wr_rd,
                                              input logic [DW-1:0] wr_data);
        if (a == REG_ZERO)               return '0;
        else if (wr_en && wr_rd == a)    return wr_data;
        else                             return gpr[a];
    endfunction

    // A landing write clears busy only when it is the last one in flight for that register.
    function automatic logic busy(input reg_addr_t a, input logic [PEND_W-1:0] cnt,
                                  input logic wre, input reg_addr_t wr_rd);
        logic dec;
        dec = wre && (wr_rd == a);
        return (a != REG_ZERO) && (cnt != CNT_ZERO) && !(dec && cnt == CNT_ONE);
    endfunction

    assign ID_RS_Data = rd_port(ID_Reg_RS, r_gpr, w_wr_en, WB_Reg_RD, WB_DataBus);
    assign ID_RT_Data = rd_port(ID_Reg_RT, r_gpr, w_wr_en, WB_Reg_RD, WB_DataBus);
    assign ID_RS_Busy = busy(ID_Reg_RS, w_cnt[ID_Reg_RS], WB_RegWre, WB_Reg_RD);
    assign ID_RT_Busy = busy(ID_Reg_RT, w_cnt[ID_Reg_RT], WB_RegWre, WB_Reg_RD);
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed-vector bench for wb_regfile_scoreboard: outputs are checked on the falling edge, state advances on the rising edge.
module tb_wb_regfile_scoreboard;
    logic        CLK = 1'b0;
    logic        RST;
    logic        WB_RegWre;
    logic [4:0]  WB_Reg_RD;
    logic [31:0] WB_DataBus;
    logic [4:0]  ID_Reg_RS, ID_Reg_RT;
    logic [31:0] ID_RS_Data, ID_RT_Data;
    logic        ID_Issue;
    logic [4:0]  ID_Issue_RD;
    logic        ID_RS_Busy, ID_RT_Busy, SB_Overflow;

    wb_regfile_scoreboard dut (
        .CLK(CLK), .RST(RST),
        .WB_RegWre(WB_RegWre), .WB_Reg_RD(WB_Reg_RD), .WB_DataBus(WB_DataBus),
        .ID_Reg_RS(ID_Reg_RS), .ID_Reg_RT(ID_Reg_RT),
        .ID_RS_Data(ID_RS_Data), .ID_RT_Data(ID_RT_Data),
        .ID_Issue(ID_Issue), .ID_Issue_RD(ID_Issue_RD),
        .ID_RS_Busy(ID_RS_Busy), .ID_RT_Busy(ID_RT_Busy), .SB_Overflow(SB_Overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, wre;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs, rt;
        logic        iss;
        logic [4:0]  ird;
        logic [31:0] ers, ert;
        logic        ebs, ebt, eovf;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic rst, logic wre, logic [4:0] rd, logic [31:0] data,
                                logic [4:0] rs, logic [4:0] rt, logic iss, logic [4:0] ird,
                                logic [31:0] ers, logic [31:0] ert,
                                logic ebs, logic ebt, logic eovf);
        vec_t v;
        v.rst = rst; v.wre = wre; v.rd = rd; v.data = data; v.rs = rs; v.rt = rt;
        v.iss = iss; v.ird = ird; v.ers = ers; v.ert = ert;
        v.ebs = ebs; v.ebt = ebt; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Drive one vector, check combinational outputs mid-cycle, then take the clock edge.
    task automatic apply(vec_t v, int idx);
        RST = v.rst; WB_RegWre = v.wre; WB_Reg_RD = v.rd; WB_DataBus = v.data;
        ID_Reg_RS = v.rs; ID_Reg_RT = v.rt; ID_Issue = v.iss; ID_Issue_RD = v.ird;
        @(negedge CLK);
        n_vec++;
        chk("rs_data",  idx, ID_RS_Data, v.ers);
        chk("rt_data",  idx, ID_RT_Data, v.ert);
        chk("rs_busy",  idx, {31'd0, ID_RS_Busy}, {31'd0, v.ebs});
        chk("rt_busy",  idx, {31'd0, ID_RT_Busy}, {31'd0, v.ebt});
        chk("overflow", idx, {31'd0, SB_Overflow}, {31'd0, v.eovf});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //        rst wre rd  data           rs  rt  iss ird  ers            ert          bs bt ov
        tbl.push_back(mk(0, 0, 0,  32'h0,         0, 31, 0, 0,  32'h0,         32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 5,  32'hDEAD_BEEF, 5, 0,  0, 0,  32'hDEAD_BEEF, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         5, 5,  0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF,0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  32'hFFFF_FFFF, 0, 5,  0, 0,  32'h0,         32'hDEAD_BEEF,0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         0, 0,  0, 0,  32'h0,         32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         7, 5,  1, 7,  32'h0,         32'hDEAD_BEEF,0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         7, 0,  1, 7,  32'h0,         32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         7, 0,  1, 7,  32'h0,         32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 7,  32'h1111_1111, 7, 0,  0, 0,  32'h1111_1111, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 1, 7,  32'h2222_2222, 7, 7,  0, 0,  32'h2222_2222, 32'h2222_2222,1, 1, 0));
        tbl.push_back(mk(0, 1, 7,  32'h3333_3333, 7, 0,  0, 0,  32'h3333_3333, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         7, 0,  0, 0,  32'h3333_3333, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  1, 9,  32'h0,         32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  32'h0000_0009, 9, 0,  1, 9,  32'h0000_0009, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  0, 0,  32'h0000_0009, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  1, 9,  32'h0000_0009, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  1, 9,  32'h0000_0009, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  1, 9,  32'h0000_0009, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         9, 0,  0, 0,  32'h0000_0009, 32'h0,        1, 0, 1));
        tbl.push_back(mk(0, 1, 9,  32'h0000_AAAA, 9, 0,  0, 0,  32'h0000_AAAA, 32'h0,        1, 0, 1));
        tbl.push_back(mk(1, 1, 3,  32'h1234_5678, 3, 9,  1, 3,  32'h1234_5678, 32'h0000_AAAA,0, 1, 1));
        tbl.push_back(mk(0, 0, 0,  32'h0,         3, 9,  0, 0,  32'h0,         32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         5, 7,  0, 0,  32'h0,         32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 4,  32'h0000_0044, 4, 0,  0, 0,  32'h0000_0044, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         4, 0,  1, 4,  32'h0000_0044, 32'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         4, 0,  1, 0,  32'h0000_0044, 32'h0,        1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  32'h0,         4, 0,  0, 0,  32'h0000_0044, 32'h0,        1, 0, 0));

        RST = 1'b1; WB_RegWre = 1'b0; WB_Reg_RD = 5'd0; WB_DataBus = 32'd0;
        ID_Reg_RS = 5'd0; ID_Reg_RT = 5'd0; ID_Issue = 1'b0; ID_Issue_RD = 5'd0;
        repeat (2) @(posedge CLK);
        #1;

        // After reset every register on both ports reads zero and nothing is busy.
        for (int a = 0; a < 32; a++) begin
            logic [4:0] ra, rb;
            ra = 5'(a);
            rb = 5'(31 - a);
            apply(mk(0, 0, 0, 32'h0, ra, rb, 0, 0, 32'h0, 32'h0, 0, 0, 0), 1000 + a);
        end

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Overflow must stay sticky across idle cycles until reset clears it.
        apply(mk(0, 0, 0, 32'h0, 0, 0, 1, 6, 32'h0, 32'h0, 0, 0, 0), 2000);
        apply(mk(0, 0, 0, 32'h0, 6, 0, 1, 6, 32'h0, 32'h0, 1, 0, 0), 2001);
        apply(mk(0, 0, 0, 32'h0, 6, 0, 1, 6, 32'h0, 32'h0, 1, 0, 0), 2002);
        apply(mk(0, 0, 0, 32'h0, 6, 0, 1, 6, 32'h0, 32'h0, 1, 0, 0), 2003);
        repeat (3) apply(mk(0, 0, 0, 32'h0, 6, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1), 2004);
        apply(mk(1, 0, 0, 32'h0, 6, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1), 2005);
        apply(mk(0, 0, 0, 32'h0, 6, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0), 2006);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
